// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(N)-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and sideband tag.
module pipelined_shifter #(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [N-1:0]     in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int L = $clog2(N);
  logic [L-1:0]            valid_q;
  logic [L-1:0][N-1:0]     data_q, data_d;
  logic [L-1:0][1:0]       op_q, op_d;
  logic [L-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [L-1:0][L-1:0]     shamt_q, shamt_d;
  logic                    adv, fix, unused;
  logic [N-1:0]            src0;
  assign adv      = !out_valid || out_ready;
  assign in_ready = !flush && adv;
  // Oversize non-rotates are resolved to their fill value at entry; zeroing the
  // carried shamt keeps later stages from touching it.
  assign fix      = |in_shamt[N-1:L] && in_op != 2'b11;
  assign src0     = !fix ? in_data : in_op == 2'b10 ? {N{in_data[N-1]}} : {N{1'b0}};
  assign op_d     = {op_q[L-2:0], in_op};
  assign tag_d    = {tag_q[L-2:0], in_tag};
  assign shamt_d  = {shamt_q[L-2:0], (fix ? {L{1'b0}} : in_shamt[L-1:0])};
  for (genvar k = 0; k < L; k++) begin : g_st
    logic [N-1:0] src;
    logic [1:0]   op;
    logic         bit_on;
    if (k == 0) begin : g_in
      assign src    = src0;
      assign op     = in_op;
      assign bit_on = shamt_d[0][0];
    end else begin : g_mid
      assign src    = data_q[k-1];
      assign op     = op_q[k-1];
      assign bit_on = shamt_q[k-1][k];
    end
    assign data_d[k] = !bit_on     ? src :
                       op == 2'b00 ? src << (2**k) :
                       op == 2'b01 ? src >> (2**k) :
                       op == 2'b10 ? N'($signed(src) >>> (2**k)) :
                                     (src >> (2**k)) | (src << (N - 2**k));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= '0;
      data_q  <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      shamt_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[L-2:0], in_valid};
      data_q  <= data_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      shamt_q <= shamt_d;
    end
  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_tag   = tag_q[L-1];
  assign busy      = |valid_q;
  assign unused    = ^{op_q, shamt_q};
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: random and directed checks of pipelined_shifter against a queue-based reference model.
module tb_pipelined_shifter;
  localparam int N = 32;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
  logic [N-1:0] in_data = 0, in_shamt = 0, out_data;
  logic [1:0] in_op = 0;
  logic [3:0] in_tag = 0, out_tag;
  int n_vec = 0, n_err = 0, run = 0, max_run = 0, n_out = 0;
  typedef struct { logic [N-1:0] d; logic [3:0] t; } exp_t;
  exp_t sb[$];

  pipelined_shifter #(.N(N), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_f(logic [N-1:0] d, logic [N-1:0] s, logic [1:0] op);
    logic [2*N-1:0] w;
    w = {d, d} >> (s % N);
    case (op)
      2'd0:    return s >= N ? '0 : d << s;
      2'd1:    return s >= N ? '0 : d >> s;
      2'd2:    return s >= N ? {N{d[N-1]}} : N'($signed(d) >>> s);
      default: return w[N-1:0];
    endcase
  endfunction

  function automatic logic [N-1:0] rnd_shamt();
    case ($urandom_range(0, 3))
      0, 1:    return N'($urandom_range(0, N-1));
      2:       return N'($urandom_range(N-2, N+2));
      default: return N'($urandom);
    endcase
  endfunction

  // Scoreboard: transfers are sampled mid-cycle, i.e. just before the edge that commits them.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      run = 0;
    end else begin
      if (out_valid && out_ready) begin
        exp_t e;
        n_out++;
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_tag", out_tag, e.t);
        end
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (flush) sb.delete();
      if (in_valid && in_ready) sb.push_back('{ref_f(in_data, in_shamt, in_op), in_tag});
    end
  end

  task automatic send(logic [N-1:0] d, logic [N-1:0] s, logic [1:0] op, logic [3:0] t);
    logic acc = 0;
    in_valid = 1; in_data = d; in_shamt = s; in_op = op; in_tag = t;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!acc) chk("accept", acc, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle", busy, 0);
  endtask

  task automatic one(logic [N-1:0] d, logic [N-1:0] s, logic [1:0] op, logic [3:0] t, logic [N-1:0] exp);
    int cnt = 0;
    in_valid = 1; in_data = d; in_shamt = s; in_op = op; in_tag = t;
    do begin
      @(posedge clk); #1;
      in_valid = 0;
      cnt++;
    end while (!out_valid && cnt < 20);
    chk("latency", cnt, 5);
    chk("one_data", out_data, exp);
    chk("one_tag", out_tag, t);
    @(posedge clk); #1;
    wait_idle();
  endtask

  initial begin
    logic [N-1:0] od;
    logic [3:0] ot;
    int base;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    chk("rst_in_ready", in_ready, 1);

    one(32'h8000_00F0, 4, 2'd2, 4'd3, 32'hF800_000F);
    one(32'h8000_0000, 40, 2'd2, 4'd1, 32'hFFFF_FFFF);
    one(32'h8000_0000, 40, 2'd1, 4'd2, 32'h0000_0000);
    one(32'h0000_0001, 31, 2'd0, 4'd4, 32'h8000_0000);
    one(32'h0000_0001, 33, 2'd3, 4'd5, 32'h8000_0000);
    one(32'h1234_5678, 0, 2'd2, 4'd6, 32'h1234_5678);
    one(32'hA5A5_0F0F, 32, 2'd3, 4'd7, 32'hA5A5_0F0F);

    max_run = 0;
    for (int i = 0; i < 8; i++) send($urandom, rnd_shamt(), i[1:0], i[3:0]);
    wait_idle();
    chk("stream_run", max_run, 8);

    out_ready = 0;
    base = n_out;
    for (int i = 0; i < 5; i++) send($urandom, rnd_shamt(), 2'($urandom), i[3:0]);
    chk("bp_out_valid", out_valid, 1);
    od = out_data; ot = out_tag;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data_stable", out_data, od);
      chk("bp_tag_stable", out_tag, ot);
    end
    out_ready = 1;
    wait_idle();
    chk("bp_count", n_out - base, 5);
    chk("bp_sb_empty", sb.size(), 0);

    for (int i = 0; i < 3; i++) send($urandom, rnd_shamt(), 2'($urandom), 4'(8 + i));
    in_valid = 1; in_data = $urandom; in_shamt = 3; in_op = 0; in_tag = 4'hB; flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    base = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_none", n_out - base, 0);

    for (int i = 0; i < 6; i++) send($urandom, rnd_shamt(), 2'($urandom), i[3:0]);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    chk("arst_in_ready", in_ready, 1);
    one(32'h1, 1, 2'd0, 4'd9, 32'h2);

    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom; in_shamt = rnd_shamt(); in_op = 2'($urandom); in_tag = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 59) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    wait_idle();
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
